// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// A one-cycle BOOT state after reset inserts a bubble before fetching starts at RESET_PC.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        PcSrc,
  input  logic [31:0] Branch_Target,
  input  logic        Jump,
  input  logic [25:0] Jump_Index,
  output logic [31:0] Imem_Addr,
  input  logic [31:0] Imem_Data,
  output logic [31:0] PC_IF_ID,
  output logic [31:0] Instr_IF_ID,
  output logic [5:0]  Opcode_IF_ID,
  output logic        Valid_IF_ID,
  output logic [31:0] Fetch_Count
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_if_id_q, pc_if_id_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        redirect;

  assign pc_plus4      = pc_q + 32'd4;
  // Jump region comes from the PC+4 of the jump itself, which sits in IF/ID.
  assign jump_target   = {pc_if_id_q[31:28], Jump_Index, 2'b00};
  assign branch_target = Branch_Target & 32'hFFFF_FFFC;
  assign redirect      = Jump | PcSrc;

  always_comb begin
    state_d    = RUN;
    pc_d       = pc_q;
    pc_if_id_d = pc_if_id_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    count_d    = count_q;
    case (state_q)
      BOOT: begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
      RUN: begin
        if (Jump)        pc_d = jump_target;
        else if (PcSrc)  pc_d = branch_target;
        else if (!Stall) pc_d = pc_plus4;

        if (redirect || Flush) begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (!Stall) begin
          pc_if_id_d = pc_plus4;
          instr_d    = Imem_Data;
          valid_d    = 1'b1;
          count_d    = count_q + 32'd1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pc_if_id_q <= 32'd0;
      instr_q    <= NOP_WORD;
      valid_q    <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_if_id_q <= pc_if_id_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  assign Imem_Addr    = pc_q;
  assign PC_IF_ID     = pc_if_id_q;
  assign Instr_IF_ID  = instr_q;
  assign Opcode_IF_ID = instr_q[31:26];
  assign Valid_IF_ID  = valid_q;
  assign Fetch_Count  = count_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the address of the first instruction fetched after reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, meaning the instruction word loaded into IF/ID on a bubble; its opcode field is 6'b000000.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 Stall  input  1  holds the PC and the IF/ID register.
REQ-006 Flush  input  1  replaces the IF/ID contents with a bubble.
REQ-007 PcSrc  input  1  branch taken, resolved in ID.
REQ-008 Branch_Target  input  32  byte address of the taken branch.
REQ-009 Jump  input  1  jump, resolved in ID.
REQ-010 Jump_Index  input  26  instr_index field of the jump in ID.
REQ-011 Imem_Addr  output  32  instruction-memory address, equal to the PC.
REQ-012 Imem_Data  input  32  instruction word returned combinationally for Imem_Addr.
REQ-013 PC_IF_ID  output  32  PC+4 of the instruction held in IF/ID.
REQ-014 Instr_IF_ID  output  32  instruction word held in IF/ID.
REQ-015 Opcode_IF_ID  output  6  Instr_IF_ID[31:26], for the control unit.
REQ-016 Valid_IF_ID  output  1  IF/ID holds a real instruction, not a bubble.
REQ-017 Fetch_Count  output  32  count of instructions accepted into IF/ID.

Function
REQ-018 The block SHALL implement a 2-state FSM: BOOT, RUN.
- Reset enters BOOT.
- BOOT lasts exactly one clock; it loads a bubble into IF/ID and the PC is not advanced.
- BOOT always transitions to RUN; RUN remains in RUN until reset.
REQ-019 In RUN, next PC priority SHALL be:
- Jump: {PC_IF_ID[31:28], Jump_Index, 2'b00}.
- Else PcSrc: {Branch_Target[31:2], 2'b00}.
- Else Stall: PC held.
- Else PC+4, modulo 2^32 (wraps 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 Jump or PcSrc SHALL override Stall for the PC update.
REQ-021 Jump, PcSrc or Flush SHALL load a bubble into IF/ID on that edge.
- Bubble: Instr=NOP_WORD, Valid=0.
- PC_IF_ID is unchanged.
- This overrides Stall.
REQ-022 Otherwise, Stall SHALL hold PC_IF_ID, Instr_IF_ID and Valid_IF_ID unchanged.
REQ-023 Otherwise, the IF/ID register SHALL load PC_IF_ID=PC+4, Instr_IF_ID=Imem_Data, Valid_IF_ID=1.
- Fetch latency: word at address A appears in IF/ID one edge after Imem_Addr=A.
REQ-024 Fetch_Count SHALL increment by 1 only on edges that load Valid_IF_ID=1 (REQ-023), wrapping modulo 2^32.
REQ-025 Opcode_IF_ID and Imem_Addr SHALL be purely combinational from registered state.
REQ-026 Jump and PcSrc asserted together SHALL resolve to the jump target; no error is flagged.

Reset
REQ-027 Asserting rst SHALL immediately, without waiting for clk, set:
- PC = RESET_PC.
- FSM state = BOOT.
- Instr_IF_ID = NOP_WORD, PC_IF_ID = 0, Valid_IF_ID = 0, Fetch_Count = 0.
REQ-028 Reset asserted mid-operation, including during Stall or a redirect, SHALL discard all in-flight state.
- The first fetch after deassertion is at RESET_PC, following the one-cycle BOOT.

Verification
REQ-029 Sequential fetch:
- Stimulus: release reset; Imem_Data = address-tagged words; no control inputs asserted.
- Response: BOOT cycle with Valid=0, then IF/ID shows word@0, word@4, word@8 on successive edges.
- PC_IF_ID = 4, 8, 12; Fetch_Count = 1, 2, 3.
REQ-030 Stall:
- Stimulus: Stall high for 3 cycles with PC=0x10.
- Response: Imem_Addr stays 0x10; IF/ID is frozen; Fetch_Count is unchanged.
- After release, word@0x10 enters IF/ID.
REQ-031 Taken branch:
- Stimulus: PcSrc=1, Branch_Target=0x0000_0102, Stall=1, same cycle.
- Response: next PC = 0x100; IF/ID holds a bubble (Valid=0, Opcode=0); Fetch_Count is unchanged.
REQ-032 Jump:
- Stimulus: PC_IF_ID=0x4000_0008, Jump=1, Jump_Index=26'h000_0040, PcSrc=1.
- Response: next PC = 0x4000_0100 (jump wins); IF/ID holds a bubble.
REQ-033 Wrap-around:
- Stimulus: PC forced via branch to 0xFFFF_FFFC, then run.
- Response: next PC = 0x0000_0000; PC_IF_ID = 0x0000_0000.
REQ-034 Asynchronous reset:
- Stimulus: assert rst mid-cycle during a stall.
- Response: outputs reach reset values before the next clk edge.
- After deassertion: one BOOT cycle, then the first valid instruction from RESET_PC.
